// File: rtl/sigmoid_bp_pkg.sv
// Shared constants, state encoding and index-width helper for the sigmoid backward-pass layer.
// Optional rounding is selected with the SIGMOID_BP_ROUND_EN macro in the datapath files.
package sigmoid_bp_pkg;

    localparam int RESOLUTION        = 16;
    localparam int FRAC_BITS         = 12;
    localparam int ONE               = 1 << FRAC_BITS;
    localparam int NUMBER_NEURON_DEF = 30;
    localparam int NEURON_IDX_W      = $clog2(NUMBER_NEURON_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sigmoid_deriv_mac.sv
// Clamp plus two-stage multiply/shift computing err * a * (1 - a); 2-cycle issue-to-write latency.
// SIGMOID_BP_ROUND_EN selects round-to-nearest (ties toward +inf) instead of truncation on both shifts.
module sigmoid_deriv_mac
    import sigmoid_bp_pkg::*;
#(
    parameter int RESOLUTION = sigmoid_bp_pkg::RESOLUTION,
    parameter int FRAC_BITS  = sigmoid_bp_pkg::FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [RESOLUTION-1:0] a_i,
    input  logic signed [RESOLUTION-1:0] err_i,
    input  logic                         issue_i,
    output logic signed [RESOLUTION-1:0] d_o,
    output logic                         wr_valid_o
);

    localparam int W2    = 2 * RESOLUTION;
    localparam int ONE_I = 1 << FRAC_BITS;
    localparam logic signed [W2-1:0] ONE_W = W2'(ONE_I);
`ifdef SIGMOID_BP_ROUND_EN
    localparam logic signed [W2-1:0] RND_W = W2'(ONE_I / 2);
`else
    localparam logic signed [W2-1:0] RND_W = '0;
`endif

    logic signed [W2-1:0]         a_ext, a_cl, prod1, sh1;
    logic signed [W2-1:0]         err_ext, p_ext, prod2, sh2;
    logic signed [RESOLUTION-1:0] p_d, p_q, err_q;
    logic                         v_q;
    logic                         unused_hi;

    // Stage 1: clamp to [0, ONE] so a*(ONE-a) stays in [0, ONE^2/4].
    always_comb begin
        a_ext = {{RESOLUTION{a_i[RESOLUTION-1]}}, a_i};
        if (a_ext < 0) begin
            a_cl = '0;
        end else if (a_ext > ONE_W) begin
            a_cl = ONE_W;
        end else begin
            a_cl = a_ext;
        end
        prod1 = a_cl * (ONE_W - a_cl);
        sh1   = (prod1 + RND_W) >>> FRAC_BITS;
        p_d   = sh1[RESOLUTION-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= 1'b0;
            p_q   <= '0;
            err_q <= '0;
        end else begin
            v_q <= issue_i;
            if (issue_i) begin
                p_q   <= p_d;
                err_q <= err_i;
            end
        end
    end

    // Stage 2 is combinational; the caller's deltas register closes the second cycle.
    always_comb begin
        err_ext = {{RESOLUTION{err_q[RESOLUTION-1]}}, err_q};
        p_ext   = {{RESOLUTION{p_q[RESOLUTION-1]}}, p_q};
        prod2   = err_ext * p_ext;
        sh2     = (prod2 + RND_W) >>> FRAC_BITS;
    end

    assign d_o        = sh2[RESOLUTION-1:0];
    assign wr_valid_o = v_q;
    assign unused_hi  = ^{sh1[W2-1:RESOLUTION], sh2[W2-1:RESOLUTION]};

endmodule

// File: rtl/sigmoid_backprop_layer.sv
// Serial local-gradient stage: delta_i = err_i * a_i * (1 - a_i) for each hidden neuron.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; SIGMOID_BP_ROUND_EN selects rounding.
module sigmoid_backprop_layer
    import sigmoid_bp_pkg::*;
#(
    parameter int NUMBER_NEURON = 30,
    parameter int RESOLUTION    = sigmoid_bp_pkg::RESOLUTION,
    parameter int FRAC_BITS     = sigmoid_bp_pkg::FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [RESOLUTION-1:0] activations [NUMBER_NEURON-1:0],
    input  logic signed [RESOLUTION-1:0] errs        [NUMBER_NEURON-1:0],
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [RESOLUTION-1:0] deltas      [NUMBER_NEURON-1:0],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = idx_width(NUMBER_NEURON);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_NEURON - 1);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d, widx_q;
    logic                         issue;
    logic signed [RESOLUTION-1:0] act_q    [NUMBER_NEURON-1:0];
    logic signed [RESOLUTION-1:0] err_q    [NUMBER_NEURON-1:0];
    logic signed [RESOLUTION-1:0] deltas_q [NUMBER_NEURON-1:0];
    logic signed [RESOLUTION-1:0] mac_d;
    logic                         mac_wv;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (mac_wv) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (issue) widx_q <= idx_q;
        end
    end

    // Operands are frozen at acceptance so the producer may change them during RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUMBER_NEURON; i++) begin
                act_q[i]    <= '0;
                err_q[i]    <= '0;
                deltas_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && in_valid) begin
                for (int i = 0; i < NUMBER_NEURON; i++) begin
                    act_q[i] <= activations[i];
                    err_q[i] <= errs[i];
                end
            end
            if (mac_wv) deltas_q[widx_q] <= mac_d;
        end
    end

    sigmoid_deriv_mac #(
        .RESOLUTION (RESOLUTION),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_i        (act_q[idx_q]),
        .err_i      (err_q[idx_q]),
        .issue_i    (issue),
        .d_o        (mac_d),
        .wr_valid_o (mac_wv)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign deltas    = deltas_q;
    assign dbg_state = state_q;

endmodule

// File: doc/sigmoid_backprop_layer.md
# sigmoid_backprop_layer

Backward-pass counterpart of the hidden-layer sigmoid activation stage. It takes the activations produced in the forward pass and the back-propagated error for each hidden neuron, and computes the local gradient for each neuron: delta_i = err_i · a_i · (1 − a_i). The neurons are processed serially through one shared two-stage multiply pipeline. It sits between the output-layer error computation and the hidden-layer weight-update logic.

## Interface
Parameters:
- NUMBER_NEURON, 30, number of hidden neurons processed per transaction
- RESOLUTION, 16, width of all signed fixed-point operands and results
- FRAC_BITS, 12, fractional bits; ONE = 2^FRAC_BITS = 4096

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset
- activations[NUMBER_NEURON-1:0]  input  RESOLUTION each, signed  forward-pass sigmoid outputs
- errs[NUMBER_NEURON-1:0]  input  RESOLUTION each, signed  back-propagated error per neuron
- in_valid  input  1  inputs valid
- in_ready  output  1  block can accept a transaction
- deltas[NUMBER_NEURON-1:0]  output  RESOLUTION each, signed  registered gradients
- out_valid  output  1  deltas complete and stable
- out_ready  input  1  consumer has taken the deltas

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, capture both arrays into internal registers and go to RUN; index=0.
  - RUN: issue neuron[index] to the pipeline each cycle and increment index. After issuing index NUMBER_NEURON-1, go to DRAIN.
  - DRAIN: wait for the last pipeline write, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Activation clamp, before stage 1: a<0 becomes 0; a>ONE becomes ONE.
- Stage 1: p = (a · (ONE − a)) >>> FRAC_BITS, registered. p lies in [0, ONE/4], so no overflow is possible.
- Stage 2: d = (err · p) >>> FRAC_BITS, computed at 2·RESOLUTION width and truncated to RESOLUTION. Because |d| ≤ |err|/4, this cannot overflow. d is written to deltas[index].
- Shifts are arithmetic; without the macro they truncate toward −∞.
- deltas hold their value from DONE until the next transaction's first write.
- Inputs are sampled only at acceptance; changes to them afterwards are ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, every deltas[i]=0, state IDLE, index=0.
- Handshake accepted at edge E0 (in_valid & in_ready).
- Stage-1 register loads neuron i at edge E(i+1).
- deltas[i] is written at edge E(i+2).
- out_valid rises at edge E(NUMBER_NEURON+1), the same edge that writes the last delta. Latency from acceptance to out_valid is NUMBER_NEURON+1 cycles.
- in_ready is low from E0 until the cycle after the out_valid/out_ready handshake. There is no same-cycle bypass and no overlap between transactions.
- out_valid holds indefinitely while out_ready=0. If out_ready is already high when out_valid rises, the handshake completes on the next edge.
- out_ready while not in DONE is ignored. in_valid while in_ready=0 is ignored.
- rst_n low in any state, including mid-RUN: on the next edge, abort, clear deltas, and return to IDLE.

## Configuration
- SIGMOID_BP_ROUND_EN defined: both shifts round to nearest by adding 2^(FRAC_BITS-1) before shifting. Ties round toward +∞.
- SIGMOID_BP_ROUND_EN undefined: both shifts truncate (arithmetic shift, toward −∞).
- The macro does not change latency or the interface.

## Structure
- Package sigmoid_bp_pkg holds:
  - RESOLUTION, FRAC_BITS and the ONE constant
  - the state typedef (IDLE, RUN, DRAIN, DONE)
  - the index width, $clog2(NUMBER_NEURON)
- Sub-module sigmoid_deriv_mac holds the clamp plus the two-stage multiply/shift datapath, including the rounding option. Its inputs are a, err and issue-valid; its outputs are d and write-valid, with fixed 2-cycle latency.
- The top level holds the FSM, index counter, input capture registers and the deltas register array.

## Test plan
- Reset check: after reset, in_ready=1, out_valid=0, all deltas=0.
- Single transaction: all a=2048, all err=4096 → all deltas=1024. out_valid asserts exactly 31 cycles after acceptance.
- Boundary values: a=0, err=4096 → 0. a=4096 → 0. a=5000 (clamped) → 0. a=−100 (clamped) → 0. a=2048 with err=−32768 → −8192.
- Rounding: a=1, err=4096 → 0 with SIGMOID_BP_ROUND_EN undefined, 1 with it defined.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid and deltas stable, in_ready=0, extra in_valid ignored. Release → in_ready=1 one cycle after the handshake.
- Mid-run reset: assert rst_n=0 at neuron 10 → next cycle IDLE, deltas=0. A new transaction then completes with correct values.
